// File: rtl/memory_cycle.sv
// MEM stage and MEM/WB register: req/ready data bus with wait-state timeout.
// Optional MISALIGN_CHECK_EN rejects misaligned half/word accesses.
module memory_cycle #(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ValidM,
    input  logic        RegWriteM,
    input  logic        MemtoRegM,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    input  logic [4:0]  RdM,
    output logic        StallM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        RegWriteW,
    output logic        MemtoRegW,
    output logic [31:0] ALUOutW,
    output logic [31:0] ReadDataW,
    output logic [4:0]  RdW,
    output logic        bus_err,
    output logic        misalign_err
);
    typedef enum logic {IDLE, ACCESS} state_t;
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    state_t state, stateNext;
    logic [31:0] addrQ, wdQ;
    logic [1:0] sizeM, sizeQ;
    logic signedQ, regWriteQ, memtoRegQ, storeQ;
    logic [4:0] rdQ;
    logic [7:0] waitCnt;
    logic memOp, misalign, issue, done, timeout, inAccess;
    logic [7:0] byteSel;
    logic [15:0] halfSel;
    logic [31:0] loadData, storeData;
    logic [3:0] storeBe;

    assign memOp = ValidM & (MemReadM | MemWriteM);

    // Store encodings 100/101 do not exist, so they fall back to word size.
    always_comb begin
        sizeM = SZ_WORD;
        unique case (funct3M)
            3'b000: sizeM = SZ_BYTE;
            3'b001: sizeM = SZ_HALF;
            3'b100: if (!MemWriteM) sizeM = SZ_BYTE;
            3'b101: if (!MemWriteM) sizeM = SZ_HALF;
            default: ;
        endcase
    end

`ifdef MISALIGN_CHECK_EN
    always_comb begin
        misalign = 1'b0;
        if (sizeM == SZ_HALF) misalign = ALUOutM[0];
        else if (sizeM == SZ_WORD) misalign = |ALUOutM[1:0];
    end
`else
    assign misalign = 1'b0;
`endif

    assign inAccess = (state == ACCESS);
    assign issue = (state == IDLE) & memOp & ~misalign;
    assign done = inAccess & dmem_ready;
    assign timeout = inAccess & ~dmem_ready & (waitCnt == WAIT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        StallM = 1'b0;
        dmem_req = 1'b0;
        unique case (state)
            IDLE: begin
                if (issue) begin
                    StallM = 1'b1;
                    stateNext = ACCESS;
                end
            end
            ACCESS: begin
                dmem_req = 1'b1;
                StallM = ~dmem_ready;
                if (done | timeout) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
        if (!rst) StallM = 1'b0;
    end

    always_comb begin
        storeBe = 4'b1111;
        storeData = wdQ;
        unique case (sizeQ)
            SZ_BYTE: begin
                storeBe = 4'b0001 << addrQ[1:0];
                storeData = {4{wdQ[7:0]}};
            end
            SZ_HALF: begin
                storeBe = addrQ[1] ? 4'b1100 : 4'b0011;
                storeData = {2{wdQ[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        unique case (addrQ[1:0])
            2'b00: byteSel = dmem_rdata[7:0];
            2'b01: byteSel = dmem_rdata[15:8];
            2'b10: byteSel = dmem_rdata[23:16];
            default: byteSel = dmem_rdata[31:24];
        endcase
    end

    assign halfSel = addrQ[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        loadData = dmem_rdata;
        unique case (sizeQ)
            SZ_BYTE: loadData = {{24{signedQ & byteSel[7]}}, byteSel};
            SZ_HALF: loadData = {{16{signedQ & halfSel[15]}}, halfSel};
            default: ;
        endcase
    end

    assign dmem_we = inAccess & storeQ;
    assign dmem_addr = inAccess ? {addrQ[31:2], 2'b00} : 32'h0;
    assign dmem_be = !inAccess ? 4'h0 : (storeQ ? storeBe : 4'b1111);
    assign dmem_wdata = (inAccess & storeQ) ? storeData : 32'h0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addrQ <= '0;
            wdQ <= '0;
            sizeQ <= '0;
            signedQ <= 1'b0;
            rdQ <= '0;
            regWriteQ <= 1'b0;
            memtoRegQ <= 1'b0;
            storeQ <= 1'b0;
            waitCnt <= '0;
        end else if (issue) begin
            addrQ <= ALUOutM;
            wdQ <= WriteDataM;
            sizeQ <= sizeM;
            signedQ <= ~funct3M[2];
            rdQ <= RdM;
            regWriteQ <= RegWriteM;
            memtoRegQ <= MemtoRegM & ~MemWriteM;
            storeQ <= MemWriteM;
            waitCnt <= '0;
        end else if (inAccess & ~dmem_ready) begin
            waitCnt <= waitCnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
            ALUOutW <= '0;
            ReadDataW <= '0;
            RdW <= '0;
            bus_err <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            bus_err <= timeout;
            misalign_err <= (state == IDLE) & memOp & misalign;
            if (inAccess) begin
                ALUOutW <= addrQ;
                RdW <= rdQ;
                RegWriteW <= done & regWriteQ;
                MemtoRegW <= done & memtoRegQ;
                ReadDataW <= (done & ~storeQ) ? loadData : 32'h0;
            end else begin
                ALUOutW <= ALUOutM;
                RdW <= RdM;
                RegWriteW <= ValidM & ~memOp & RegWriteM;
                MemtoRegW <= ValidM & ~memOp & MemtoRegM;
                ReadDataW <= '0;
            end
        end
    end
endmodule

// File: tb/tb_memory_cycle.sv
// Scoreboard bench for memory_cycle; exercises MISALIGN_CHECK_EN when defined.
module tb_memory_cycle;
    localparam int MAXW = 4;

    logic clk = 1'b0;
    logic rst;
    logic ValidM, RegWriteM, MemtoRegM, MemReadM, MemWriteM;
    logic [2:0] funct3M;
    logic [31:0] ALUOutM, WriteDataM;
    logic [4:0] RdM;
    logic StallM, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0] dmem_be;
    logic dmem_ready;
    logic RegWriteW, MemtoRegW;
    logic [31:0] ALUOutW, ReadDataW;
    logic [4:0] RdW;
    logic bus_err, misalign_err;

    always #5 clk = ~clk;

    memory_cycle #(.MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst),
        .ValidM(ValidM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM), .funct3M(funct3M),
        .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .RdM(RdM),
        .StallM(StallM), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .ALUOutW(ALUOutW),
        .ReadDataW(ReadDataW), .RdW(RdW),
        .bus_err(bus_err), .misalign_err(misalign_err)
    );

    typedef struct {
        logic rw;
        logic m2r;
        logic busErr;
        logic misErr;
        logic [31:0] alu;
        logic [31:0] rdat;
        logic [4:0] rd;
        logic chkData;
    } wb_t;

    wb_t sb[$];
    int nCmp = 0;
    int nBad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCmp++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic wb_t mk(input logic rw, m2r, be, me, input logic [31:0] alu, rdat,
                               input logic [4:0] rd, input logic cd);
        wb_t w;
        w.rw = rw; w.m2r = m2r; w.busErr = be; w.misErr = me;
        w.alu = alu; w.rdat = rdat; w.rd = rd; w.chkData = cd;
        return w;
    endfunction

    task automatic idleInputs();
        ValidM = 1'b0; RegWriteM = 1'b0; MemtoRegM = 1'b0;
        MemReadM = 1'b0; MemWriteM = 1'b0; funct3M = 3'b000;
        ALUOutM = 32'h0; WriteDataM = 32'h0; RdM = 5'd0;
        dmem_ready = 1'b0; dmem_rdata = 32'h0;
    endtask

    // readyAt: ACCESS cycle with dmem_ready, -1 never (timeout), -2 no bus access
    task automatic runOp(input string tag, input logic [2:0] f3, input logic rdM, wrM, rwM, m2rM,
                         input logic [31:0] addr, wd, input logic [4:0] rd,
                         input int readyAt, input logic [31:0] rdata,
                         input logic [31:0] expAddr, input logic [3:0] expBe,
                         input logic [31:0] expWd, input wb_t exp);
        int nAcc, stalls, expStall;
        wb_t e;
        nAcc = (readyAt == -2) ? 0 : (readyAt == -1) ? MAXW : readyAt + 1;
        expStall = (nAcc == 0) ? 0 : nAcc + ((readyAt == -1) ? 1 : 0);
        stalls = 0;
        sb.push_back(exp);
        @(posedge clk); #1;
        ValidM = 1'b1; RegWriteM = rwM; MemtoRegM = m2rM;
        MemReadM = rdM; MemWriteM = wrM; funct3M = f3;
        ALUOutM = addr; WriteDataM = wd; RdM = rd; dmem_ready = 1'b0;
        @(negedge clk);
        if (StallM) stalls++;
        if (nAcc == 0) chk({tag, ".noReq"}, dmem_req, 1'b0);
        for (int c = 0; c < nAcc; c++) begin
            @(posedge clk); #1;
            dmem_ready = (c == readyAt);
            dmem_rdata = rdata;
            @(negedge clk);
            if (StallM) stalls++;
            chk({tag, ".req"}, dmem_req, 1'b1);
            if (c == 0 || c == nAcc - 1) begin
                chk({tag, ".addr"}, dmem_addr, expAddr);
                chk({tag, ".be"}, dmem_be, expBe);
                chk({tag, ".we"}, dmem_we, wrM);
                if (wrM) chk({tag, ".wdata"}, dmem_wdata, expWd);
            end
        end
        @(posedge clk); #1;
        idleInputs();
        @(negedge clk);
        chk({tag, ".stalls"}, stalls, expStall);
        if (sb.size() == 0) begin
            nCmp++; nBad++;
            $display("FAIL %s.sb: got empty queue expected entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".RegWriteW"}, RegWriteW, e.rw);
            chk({tag, ".bus_err"}, bus_err, e.busErr);
            chk({tag, ".misalign_err"}, misalign_err, e.misErr);
            chk({tag, ".ALUOutW"}, ALUOutW, e.alu);
            if (e.rw) begin
                chk({tag, ".MemtoRegW"}, MemtoRegW, e.m2r);
                chk({tag, ".RdW"}, RdW, e.rd);
            end
            if (e.chkData) chk({tag, ".ReadDataW"}, ReadDataW, e.rdat);
        end
        chk({tag, ".idleReq"}, dmem_req, 1'b0);
        chk({tag, ".idleStall"}, StallM, 1'b0);
        @(negedge clk);
        chk({tag, ".errClear"}, {30'h0, bus_err, misalign_err}, 32'h0);
    endtask

    initial begin
        rst = 1'b0;
        idleInputs();
        repeat (2) @(negedge clk);
        chk("rst.StallM", StallM, 1'b0);
        chk("rst.req", dmem_req, 1'b0);
        chk("rst.be", dmem_be, 4'h0);
        chk("rst.RegWriteW", RegWriteW, 1'b0);
        chk("rst.ALUOutW", ALUOutW, 32'h0);
        chk("rst.errs", {30'h0, bus_err, misalign_err}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;

        runOp("alu", 3'b000, 0, 0, 1, 0, 32'h0000_1234, 32'h0, 5'd5, -2, 32'h0,
              32'h0, 4'h0, 32'h0, mk(1, 0, 0, 0, 32'h0000_1234, 32'h0, 5'd5, 1));
        runOp("lb", 3'b000, 1, 0, 1, 1, 32'h0000_0103, 32'h0, 5'd7, 2, 32'h80AA_BBCC,
              32'h0000_0100, 4'hF, 32'h0, mk(1, 1, 0, 0, 32'h0000_0103, 32'hFFFF_FF80, 5'd7, 1));
        runOp("lhu", 3'b101, 1, 0, 1, 1, 32'h0000_0102, 32'h0, 5'd8, 0, 32'h8001_0000,
              32'h0000_0100, 4'hF, 32'h0, mk(1, 1, 0, 0, 32'h0000_0102, 32'h0000_8001, 5'd8, 1));
        runOp("lh", 3'b001, 1, 0, 1, 1, 32'h0000_0102, 32'h0, 5'd9, 1, 32'h8001_0000,
              32'h0000_0100, 4'hF, 32'h0, mk(1, 1, 0, 0, 32'h0000_0102, 32'hFFFF_8001, 5'd9, 1));
        runOp("lbu", 3'b100, 1, 0, 1, 1, 32'h0000_0101, 32'h0, 5'd10, 0, 32'h1234_F678,
              32'h0000_0100, 4'hF, 32'h0, mk(1, 1, 0, 0, 32'h0000_0101, 32'h0000_00F6, 5'd10, 1));
        runOp("sb", 3'b000, 0, 1, 0, 0, 32'h0000_0201, 32'h1122_33A5, 5'd0, 0, 32'hFFFF_FFFF,
              32'h0000_0200, 4'b0010, 32'hA5A5_A5A5, mk(0, 0, 0, 0, 32'h0000_0201, 32'h0, 5'd0, 1));
        runOp("sh", 3'b001, 0, 1, 0, 0, 32'h0000_0202, 32'hDEAD_BEEF, 5'd0, 2, 32'h0,
              32'h0000_0200, 4'b1100, 32'hBEEF_BEEF, mk(0, 0, 0, 0, 32'h0000_0202, 32'h0, 5'd0, 1));
        runOp("sw", 3'b010, 0, 1, 0, 0, 32'h0000_0204, 32'hCAFE_F00D, 5'd0, 1, 32'h0,
              32'h0000_0204, 4'b1111, 32'hCAFE_F00D, mk(0, 0, 0, 0, 32'h0000_0204, 32'h0, 5'd0, 1));
        runOp("rdwr", 3'b000, 1, 1, 0, 0, 32'h0000_0003, 32'h0000_005A, 5'd0, 0, 32'h7777_7777,
              32'h0000_0000, 4'b1000, 32'h5A5A_5A5A, mk(0, 0, 0, 0, 32'h0000_0003, 32'h0, 5'd0, 1));
        runOp("tmo", 3'b010, 1, 0, 1, 1, 32'h0000_0300, 32'h0, 5'd11, -1, 32'h0,
              32'h0000_0300, 4'hF, 32'h0, mk(0, 0, 1, 0, 32'h0000_0300, 32'h0, 5'd11, 0));
        runOp("lw", 3'b010, 1, 0, 1, 1, 32'h0000_0308, 32'h0, 5'd12, 3, 32'h1357_9BDF,
              32'h0000_0308, 4'hF, 32'h0, mk(1, 1, 0, 0, 32'h0000_0308, 32'h1357_9BDF, 5'd12, 1));
`ifdef MISALIGN_CHECK_EN
        runOp("misLW", 3'b010, 1, 0, 1, 1, 32'h0000_0102, 32'h0, 5'd13, -2, 32'h0,
              32'h0, 4'h0, 32'h0, mk(0, 0, 0, 1, 32'h0000_0102, 32'h0, 5'd13, 0));
        runOp("misLH", 3'b001, 1, 0, 1, 1, 32'h0000_0105, 32'h0, 5'd14, -2, 32'h0,
              32'h0, 4'h0, 32'h0, mk(0, 0, 0, 1, 32'h0000_0105, 32'h0, 5'd14, 0));
`else
        runOp("uaLW", 3'b010, 1, 0, 1, 1, 32'h0000_0102, 32'h0, 5'd13, 0, 32'h1122_3344,
              32'h0000_0100, 4'hF, 32'h0, mk(1, 1, 0, 0, 32'h0000_0102, 32'h1122_3344, 5'd13, 1));
`endif

        @(posedge clk); #1;
        ValidM = 1'b1; MemReadM = 1'b1; funct3M = 3'b010;
        ALUOutM = 32'h0000_0400; RegWriteM = 1'b1; MemtoRegM = 1'b1; RdM = 5'd3;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midRst.reqBefore", dmem_req, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("midRst.req", dmem_req, 1'b0);
        chk("midRst.StallM", StallM, 1'b0);
        chk("midRst.be", dmem_be, 4'h0);
        @(posedge clk); #1;
        idleInputs();
        rst = 1'b1;
        runOp("postRst", 3'b000, 0, 0, 1, 0, 32'h0000_00AB, 32'h0, 5'd31, -2, 32'h0,
              32'h0, 4'h0, 32'h0, mk(1, 0, 0, 0, 32'h0000_00AB, 32'h0, 5'd31, 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule
